fetch_stage: RTL
================

# fetch_stage

Parametrised instruction-fetch front end for the out-of-order core. Owns the PC, issues single-word reads to the I-cache upstream port, and buffers returned instructions with their PCs in an internal circular queue for decode. Adds redirect/flush with kill of an in-flight cache response, queue-credit back-pressure and back-to-back issue.

## Interface
Parameters:
- RESET_PC, 32'h1eceb000, PC loaded on reset.
- QUEUE_DEPTH, 16, instruction queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  fetch address; held stable while a request is outstanding.
- imem_rmask  out  4  4'hf for exactly one cycle per issued request, otherwise 0.
- imem_rdata  in  32  instruction word, valid with imem_resp.
- imem_resp  in  1  one-cycle response for the outstanding request.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and treated as 0.
- deq_valid  out  1  queue not empty.
- deq_inst  out  32  instruction at queue head.
- deq_pc  out  32  PC of the head instruction.
- deq_ready  in  1  decode consumes the head when deq_valid && deq_ready.
- occupancy  out  $clog2(QUEUE_DEPTH)+1  registered entry count.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: a request is outstanding.
  - KILL: a request is outstanding but stale; its response is discarded.
- IDLE: issue when occupancy < QUEUE_DEPTH. On issue, imem_addr = pc, imem_rmask = 4'hf, and the FSM moves to WAIT.
- WAIT, on imem_resp:
  - Enqueue {imem_rdata, pc} and set pc <= pc+4.
  - If occupancy < QUEUE_DEPTH-1, issue pc+4 in the same cycle (imem_addr = pc+4) and stay in WAIT. Otherwise go to IDLE.
- KILL, on imem_resp: drop the response and go to IDLE.
- Redirect has the highest priority:
  - Actions: queue flushed (occupancy <= 0, head = tail); pc <= redirect_pc; a concurrent dequeue is ignored.
  - IDLE -> IDLE, with issue on the next cycle.
  - WAIT without a same-cycle imem_resp -> KILL.
  - WAIT with a same-cycle imem_resp -> response dropped, IDLE.
  - KILL -> pc updated; stays KILL unless imem_resp arrives that cycle, then IDLE.
  - Redirect suppresses any same-cycle back-to-back issue.
- Queue behaviour:
  - Head/tail pointers are log2(QUEUE_DEPTH) bits and wrap modulo QUEUE_DEPTH.
  - Occupancy updates by +1 on enqueue, -1 on dequeue, 0 when both happen.
  - Dequeue when empty has no effect.
  - Enqueue cannot occur when full, because the credit check is done at issue.
- PC arithmetic is 32-bit modulo; 32'hfffffffc+4 = 0.

## Timing
- Reset values: pc = RESET_PC, state IDLE, occupancy 0, deq_valid 0, imem_rmask 0. imem_addr = RESET_PC.
- Reset asserted mid-request: state is lost and a later imem_resp is ignored (the cache is reset with the block).
- First issue is in the first cycle after rst deasserts.
- Latency: response in cycle N gives deq_valid = 1 in cycle N+1.
- Throughput: one instruction per cache response; no idle cycle between requests while credit exists.
- deq_inst and deq_pc come from registered storage and are valid whenever deq_valid is high.
- imem_addr is combinational from FSM, pc and the issue decision; it must not depend on deq_ready.

## Configuration
- FETCH_REDIRECT_BYPASS_EN defined:
  - A redirect seen in IDLE with occupancy-after-flush credit issues redirect_pc in the same cycle (imem_addr = redirect_pc, imem_rmask = 4'hf) and moves to WAIT.
  - A redirect arriving with a same-cycle imem_resp in WAIT behaves the same way.
- Not defined: the redirect only loads pc, and issue happens the following cycle (one bubble).

## Test plan
- Reset, cache responding 1 cycle after each issue, deq_ready = 1 -> issued addresses 1eceb000, 1eceb004, 1eceb008, ... back-to-back; deq_pc sequence matches; occupancy stays <= 1.
- QUEUE_DEPTH = 4, deq_ready = 0 -> exactly 4 requests issued; occupancy = 4; imem_rmask stays 0. Then deq_ready = 1 for one cycle -> occupancy 3 and a new issue follows.
- Redirect to 32'h1000 two cycles after an issue, response arriving 3 cycles later -> stale word not enqueued. The next issue is at 32'h1000; the queue is empty at the redirect edge.
- Redirect in the same cycle as imem_resp and deq_ready = 1 -> response dropped, dequeue ignored, occupancy 0. Next imem_addr = redirect_pc, issued the same cycle with the macro and the next cycle without it.
- Queue wrap: depth 4, 10 enqueues with interleaved dequeues -> FIFO order and PCs preserved across pointer wrap; occupancy never exceeds 4.
- Async reset asserted mid-WAIT -> outputs reach reset values before the next clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end.
//
// Owns the fetch PC, issues single-word reads to the I-cache and buffers the
// returned words, together with their PCs, in a circular queue for decode.
// A redirect flushes the queue and restarts fetch; a response belonging to
// a request issued before the redirect is discarded.
//
// Optional feature macro: FETCH_REDIRECT_BYPASS_EN
//   defined   : a redirect taken in IDLE, or in WAIT together with a
//               response, issues redirect_pc in the same cycle.
//   undefined : a redirect only loads the PC; issue follows one cycle later.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   imem_addr       fetch address (combinational)
//   imem_rmask      4'hf for the single issue cycle of a request, else 0
//   imem_rdata      returned instruction word, qualified by imem_resp
//   imem_resp       one-cycle response for the outstanding request
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new fetch PC (bits [1:0] ignored)
//   deq_valid       queue not empty
//   deq_inst        instruction at queue head
//   deq_pc          PC of the head instruction
//   deq_ready       decode consumes the head when deq_valid && deq_ready
//   occupancy       registered entry count
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h1eceb000,
    parameter int          QUEUE_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [31:0]                  imem_addr,
    output logic [3:0]                   imem_rmask,
    input  logic [31:0]                  imem_rdata,
    input  logic                         imem_resp,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         deq_valid,
    output logic [31:0]                  deq_inst,
    output logic [31:0]                  deq_pc,
    input  logic                         deq_ready,
    output logic [$clog2(QUEUE_DEPTH):0] occupancy
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(QUEUE_DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_M1  = OCC_W'(QUEUE_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic [31:0]       inst_mem_q [QUEUE_DEPTH];
    logic [31:0]       pc_mem_q   [QUEUE_DEPTH];

    logic              issue;
    logic              enq;
    logic              deq;
    logic [31:0]       redir_pc;
    logic [31:0]       pc_inc;

    // The two low bits of redirect_pc are forced to zero and never read.
    logic              unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign redir_pc  = {redirect_pc[31:2], 2'b00};
    assign pc_inc    = pc_q + 32'd4;
    assign deq_valid = (occ_q != '0);
    assign deq_inst  = inst_mem_q[head_q];
    assign deq_pc    = pc_mem_q[head_q];
    assign occupancy = occ_q;
    assign imem_rmask = issue ? 4'hf : 4'h0;

    // A redirect wins over a concurrent dequeue.
    assign deq = deq_valid && deq_ready && !redirect_valid;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        issue     = 1'b0;
        enq       = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
`ifdef FETCH_REDIRECT_BYPASS_EN
                    // After the flush the queue is empty, so credit exists.
                    issue     = 1'b1;
                    imem_addr = redir_pc;
                    state_d   = WAIT;
`endif
                end else if (occ_q < DEPTH_OCC) begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (imem_resp) begin
`ifdef FETCH_REDIRECT_BYPASS_EN
                        issue     = 1'b1;
                        imem_addr = redir_pc;
                        state_d   = WAIT;
`else
                        state_d   = IDLE;
`endif
                    end else begin
                        // Response still to come belongs to the old stream.
                        state_d = KILL;
                    end
                end else if (imem_resp) begin
                    enq  = 1'b1;
                    pc_d = pc_inc;
                    // Keep one slot for the word being enqueued this cycle.
                    if (occ_q < DEPTH_M1) begin
                        issue     = 1'b1;
                        imem_addr = pc_inc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            KILL: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end
                if (imem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // No request may leave the block while it is held in reset.
        if (rst) begin
            issue     = 1'b0;
            imem_addr = pc_q;
        end
    end

    always_comb begin
        tail_d = tail_q;
        head_d = head_q;
        occ_d  = occ_q;
        if (redirect_valid) begin
            head_d = tail_q;
            occ_d  = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
        end
    end

    // Queue storage carries data only; validity comes from occ_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem_q[tail_q] <= imem_rdata;
            pc_mem_q[tail_q]   <= pc_q;
        end
    end

endmodule
